// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared types and constants for the sample quad gatherer and its holding
// register.
//   QUAD_LANES    lanes per group handed to the four-input minimum stage
//   cnt_t         fill counter type (0..3)
//   hold_state_t  holding register state (EMPTY/FULL)
//   quad_t        four lanes at the default sample width
//   PAD_VALUE     all-ones filler for unused lanes, so padding never wins a min
//   real_lanes()  number of real lanes in a group closing now
// Optional feature macro used by the users of this package:
//   SAMPLE_QUAD_NVALID_EN
// -----------------------------------------------------------------------------
package quad_pkg;

   localparam int QUAD_LANES = 4;
   localparam int QUAD_W     = 8;

   typedef logic [1:0] cnt_t;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   typedef struct packed {
      logic [QUAD_W-1:0] d;
      logic [QUAD_W-1:0] c;
      logic [QUAD_W-1:0] b;
      logic [QUAD_W-1:0] a;
   } quad_t;

   localparam logic [QUAD_W-1:0] PAD_VALUE = '1;

   // Staged lanes plus the sample arriving on the closing edge, if any.
   function automatic logic [2:0] real_lanes(input cnt_t staged, input logic with_sample);
      return {1'b0, staged} + {2'b00, with_sample};
   endfunction

endpackage

// File: rtl/quad_out_reg.sv
// -----------------------------------------------------------------------------
// quad_out_reg
// Output holding register for one quad with valid/ready handshake.
// Handshake: a quad transfers on a rising edge where out_valid && out_ready;
// out_valid, once high, stays high and the lanes stay stable until that
// transfer. A load may coincide with a transfer (drain and reload on the same
// edge), in which case out_valid stays high with the new quad. The caller
// only loads when the register is EMPTY or being drained this cycle.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   load, load_lanes    new quad to capture (lane 0 = oldest)
//   load_nvalid         real lane count of the new quad (SAMPLE_QUAD_NVALID_EN)
//   out_valid/out_ready output handshake
//   out_lanes           held quad
//   out_nvalid          real lane count of the held quad (SAMPLE_QUAD_NVALID_EN)
//   state               holding state, exposed for observation
// -----------------------------------------------------------------------------
module quad_out_reg
   import quad_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  load,
   input  logic [QUAD_LANES-1:0][WIDTH-1:0]      load_lanes,
`ifdef SAMPLE_QUAD_NVALID_EN
   input  logic [2:0]                            load_nvalid,
   output logic [2:0]                            out_nvalid,
`endif
   input  logic                                  out_ready,
   output logic                                  out_valid,
   output logic [QUAD_LANES-1:0][WIDTH-1:0]      out_lanes,
   output hold_state_t                           state
);

   hold_state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HOLD_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HOLD_EMPTY: if (load) state_d = HOLD_FULL;
         HOLD_FULL:  if (!load && out_ready) state_d = HOLD_EMPTY;
         default:    state_d = HOLD_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_lanes <= '0;
      end else if (load) begin
         out_lanes <= load_lanes;
      end
   end

`ifdef SAMPLE_QUAD_NVALID_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         out_nvalid <= '0;
      end else if (load) begin
         out_nvalid <= load_nvalid;
      end
   end
`endif

   assign out_valid = (state_q == HOLD_FULL);
   assign state     = state_q;

endmodule

// File: rtl/sample_quad_gatherer.sv
// -----------------------------------------------------------------------------
// sample_quad_gatherer
// Packs a stream of WIDTH-bit samples into quads for the four-input minimum
// stage. A flush closes a partial group, padding unused lanes with all-ones.
// Handshakes: a sample transfers on a rising edge with in_valid && in_ready;
// a quad transfers on a rising edge with out_valid && out_ready. Neither
// side's valid depends on its own ready.
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   in_valid, in_ready, in_data  sample input handshake
//   flush                        one-cycle request to close the partial group
//   out_valid, out_ready         quad output handshake
//   out_a..out_d                 quad lanes, a = oldest sample
//   out_nvalid                   real lanes in the held quad, 1..4
//                                (only with SAMPLE_QUAD_NVALID_EN defined)
// -----------------------------------------------------------------------------
module sample_quad_gatherer
   import quad_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d
`ifdef SAMPLE_QUAD_NVALID_EN
   ,
   output logic [2:0]       out_nvalid
`endif
);

   localparam logic [WIDTH-1:0] PAD = {WIDTH{1'b1}};

   cnt_t                             cnt;
   logic [2:0][WIDTH-1:0]            stage;
   logic                             flush_pend;
   logic [QUAD_LANES-1:0][WIDTH-1:0] load_lanes;
   logic [QUAD_LANES-1:0][WIDTH-1:0] out_lanes;
   hold_state_t                      hold_state;

   logic accept;
   logic can_close;
   logic flush_req;
   logic close_full;
   logic close_flush;
   logic close;

   // Only a full group needs the holding register; a partial group keeps
   // filling while the held quad waits.
   assign in_ready    = !reset && !((cnt == 2'd3) && out_valid && !out_ready);
   assign accept      = in_valid && in_ready;
   assign can_close   = !out_valid || out_ready;
   assign flush_req   = flush || flush_pend;
   assign close_full  = accept && (cnt == 2'd3);
   assign close_flush = flush_req && ((cnt != 2'd0) || accept) && can_close;
   assign close       = close_full || close_flush;

   // Lanes below cnt come from staging, lane cnt takes the incoming sample,
   // everything above is padding.
   always_comb begin
      load_lanes = '0;
      for (int i = 0; i < 3; i++) begin
         if (cnt_t'(i) < cnt) begin
            load_lanes[i] = stage[i];
         end else if ((cnt_t'(i) == cnt) && accept) begin
            load_lanes[i] = in_data;
         end else begin
            load_lanes[i] = PAD;
         end
      end
      load_lanes[3] = close_full ? in_data : PAD;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         stage      <= '0;
         flush_pend <= 1'b0;
      end else if (close) begin
         cnt        <= '0;
         flush_pend <= 1'b0;
      end else begin
         if (accept && (cnt != 2'd3)) begin
            stage[cnt] <= in_data;
            cnt        <= cnt + 2'd1;
         end
         // A flush that cannot close now waits for the holding register.
         flush_pend <= flush_req && ((cnt != 2'd0) || accept);
      end
   end

   quad_out_reg #(
      .WIDTH (WIDTH)
   ) u_out_reg (
      .clk         (clk),
      .reset       (reset),
      .load        (close),
      .load_lanes  (load_lanes),
`ifdef SAMPLE_QUAD_NVALID_EN
      .load_nvalid (real_lanes(cnt, accept)),
      .out_nvalid  (out_nvalid),
`endif
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_lanes   (out_lanes),
      .state       (hold_state)
   );

   assign out_a = out_lanes[0];
   assign out_b = out_lanes[1];
   assign out_c = out_lanes[2];
   assign out_d = out_lanes[3];

endmodule

// File: tb/tb_sample_quad_gatherer.sv
// -----------------------------------------------------------------------------
// tb_sample_quad_gatherer
// Bench for sample_quad_gatherer. A queue-based model tracks the open group,
// the held quad and any pending flush; a negedge process compares every
// output against it and checks emitted quads in order. Directed scenarios
// add literal expectations, then randomized traffic runs.
// Optional macro: SAMPLE_QUAD_NVALID_EN (adds out_nvalid checks).
// -----------------------------------------------------------------------------
module tb_sample_quad_gatherer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_a, out_b, out_c, out_d;
`ifdef SAMPLE_QUAD_NVALID_EN
   logic [2:0]   out_nvalid;
`endif

   int vectors     = 0;
   int miscompares = 0;
   bit check_en    = 1'b0;

   // model state
   logic [W-1:0]   grp[$];
   logic [4*W-1:0] exp_q[$];
   logic           m_valid = 1'b0;
   logic [W-1:0]   m_lane[4];
   int             m_nvalid = 0;
   logic           m_pend = 1'b0;

   sample_quad_gatherer #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_c      (out_c),
      .out_d      (out_d)
`ifdef SAMPLE_QUAD_NVALID_EN
      ,
      .out_nvalid (out_nvalid)
`endif
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_in_ready();
      return !reset && !((grp.size() == 3) && m_valid && !out_ready);
   endfunction

   task automatic model_update();
      bit acc, can_close, drain, close, freq;
      if (reset) begin
         grp.delete();
         exp_q.delete();
         m_valid  = 1'b0;
         m_nvalid = 0;
         m_pend   = 1'b0;
         for (int i = 0; i < 4; i++) m_lane[i] = '0;
         return;
      end
      acc       = in_valid && m_in_ready();
      can_close = !m_valid || out_ready;
      drain     = m_valid && out_ready;
      freq      = flush || m_pend;
      if (acc) grp.push_back(in_data);
      close = (grp.size() == 4) || (freq && (grp.size() > 0) && can_close);
      if (close) begin
         for (int i = 0; i < 4; i++) m_lane[i] = (i < grp.size()) ? grp[i] : {W{1'b1}};
         m_nvalid = grp.size();
         m_valid  = 1'b1;
         exp_q.push_back({m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
         grp.delete();
         m_pend = 1'b0;
      end else begin
         if (drain) m_valid = 1'b0;
         m_pend = freq && (grp.size() > 0);
      end
   endtask

   // one clock: model advances on the same edge as the DUT
   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic fl);
      in_valid = 1'b1;
      in_data  = d;
      flush    = fl;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
      tick();
   endtask

   task automatic lit_quad(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_a"}, out_a, a);
      chk({name, "_b"}, out_b, b);
      chk({name, "_c"}, out_c, c);
      chk({name, "_d"}, out_d, d);
   endtask

   // compare process + scoreboard
   always @(negedge clk) begin
      logic [4*W-1:0] e;
      if (check_en) begin
         chk("in_ready", in_ready, m_in_ready());
         chk("out_valid", out_valid, m_valid);
         chk("out_a", out_a, m_lane[0]);
         chk("out_b", out_b, m_lane[1]);
         chk("out_c", out_c, m_lane[2]);
         chk("out_d", out_d, m_lane[3]);
`ifdef SAMPLE_QUAD_NVALID_EN
         chk("out_nvalid", out_nvalid, m_nvalid);
`endif
         if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_quad", {out_d, out_c, out_b, out_a}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_quad", {out_d, out_c, out_b, out_a}, e);
            end
         end
      end
   end

   // driver
   initial begin
      for (int i = 0; i < 4; i++) m_lane[i] = '0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      tick();
      check_en = 1'b1;
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_d", out_d, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // 9,3,7,5
      send(8'd9, 0); chk("t1_rdy0", in_ready, 1);
      send(8'd3, 0); chk("t1_rdy1", in_ready, 1);
      send(8'd7, 0); chk("t1_rdy2", in_ready, 1);
      chk("t1_not_yet", out_valid, 0);
      send(8'd5, 0); chk("t1_rdy3", in_ready, 1);
      lit_quad("t1", 8'd9, 8'd3, 8'd7, 8'd5);
      idle();

      // continuous 1..12
      for (int i = 1; i <= 12; i++) begin
         send(W'(i), 0);
         chk("t2_rdy", in_ready, 1);
         if (i % 4 == 0) lit_quad("t2", W'(i - 3), W'(i - 2), W'(i - 1), W'(i));
      end
      idle();

      // 20,10 then flush alone
      send(8'd20, 0);
      send(8'd10, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      lit_quad("t3", 8'd20, 8'd10, 8'hFF, 8'hFF);
`ifdef SAMPLE_QUAD_NVALID_EN
      chk("t3_nvalid", out_nvalid, 2);
`endif
      idle();

      // backpressure with drain and reload on one edge
      send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
      out_ready = 1'b0;
      send(8'd5, 0); send(8'd6, 0); send(8'd7, 0);
      in_valid = 1'b1;
      in_data  = 8'd8;
      #1;
      chk("t4_stall", in_ready, 0);
      tick(); tick();
      chk("t4_hold_rdy", in_ready, 0);
      lit_quad("t4_held", 8'd1, 8'd2, 8'd3, 8'd4);
      out_ready = 1'b1;
      #1;
      chk("t4_unstall", in_ready, 1);
      tick();
      in_valid = 1'b0;
      lit_quad("t4_reload", 8'd5, 8'd6, 8'd7, 8'd8);
      idle();
      chk("t4_drained", out_valid, 0);

      // flush with nothing staged, then flush with the 3rd sample
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_empty_flush", out_valid, 0);
      send(8'd11, 0); send(8'd22, 0); send(8'd33, 1);
      lit_quad("t5", 8'd11, 8'd22, 8'd33, 8'hFF);
`ifdef SAMPLE_QUAD_NVALID_EN
      chk("t5_nvalid", out_nvalid, 3);
`endif
      idle();

      // reset mid-operation: held quad, cnt=2, pending flush
      out_ready = 1'b0;
      send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
      send(8'd5, 0); send(8'd6, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_valid", out_valid, 0);
      chk("t6_a", out_a, 0);
      chk("t6_d", out_d, 0);
      out_ready = 1'b1;
      send(8'd40, 0);
      chk("t6_no_stale", out_valid, 0);
      send(8'd41, 0); send(8'd42, 0); send(8'd43, 0);
      lit_quad("t6", 8'd40, 8'd41, 8'd42, 8'd43);
      idle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 249) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = W'($urandom_range(0, 255));
         flush     = ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      reset     = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sample_quad_gatherer.md
Name: sample_quad_gatherer

Overview:
- Streaming front-end for the four-input minimum stage.
- Accepts one WIDTH-bit sample per cycle over a valid/ready handshake and packs consecutive samples into groups of four.
- Presents each group as a registered quad (out_a..out_d) with its own valid/ready handshake, directly feeding the min stage's a/b/c/d inputs.
- A flush request closes a partial group by padding unused lanes with all-ones, so padding never wins the minimum.

Parameters:
- WIDTH, 8, sample width in bits; matches the min stage's operand width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  WIDTH  sample
- flush  input  1  single-cycle request to emit the partial group now
- out_valid  output  1  quad held and valid
- out_ready  input  1  downstream accepts the quad
- out_a / out_b / out_c / out_d  output  WIDTH each  quad lanes in arrival order (a = oldest)

Behaviour:
- Transfers happen only on clock edges.
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- State:
  - Fill counter cnt (0..3).
  - Three staging registers for lanes a..c.
  - Output holding register (EMPTY/FULL) with lanes a..d.
- Reset (synchronous, active-high): cnt=0, out_valid=0, out_a..out_d=0. in_ready is 0 during the reset cycle and 1 on the first cycle after.
- Fill: an accepted sample with cnt<3 is stored in lane cnt, then cnt++.
- Close: a group closes on either:
  - an accepted sample with cnt==3, or
  - flush with cnt>0.
  - On close, the staged lanes (plus the incoming sample, if any) load the holding register, unfilled lanes become all-ones, cnt becomes 0 and out_valid becomes 1.
- Latency: out_valid rises the cycle after the closing edge.
- Flush:
  - flush together with an accepted sample: the sample is included first, then the group closes. Example: cnt=1 plus sample plus flush gives lanes a,b real and c,d padded.
  - flush with cnt==0 and no accepted sample: no effect.
  - flush while a close cannot proceed (holding register FULL and out_ready=0): the request is held pending and honoured at the first possible cycle. It does not stall in_ready for cnt<3.
- Backpressure:
  - in_ready = !(cnt==3 && out_valid && !out_ready), so throughput is 1 sample/cycle when downstream is always ready.
  - A close is permitted when the holding register is EMPTY or is being drained in the same cycle (simultaneous output transfer and reload leaves out_valid=1 with the new quad).
- Holding register: out_a..out_d are stable while out_valid && !out_ready. out_valid drops only after an output transfer with no simultaneous reload.
- Reset mid-operation discards the partial group, any pending flush and the held quad. Nothing is emitted.
- Wrap: cnt wraps 3 -> 0 only on close. There is no other overflow condition.

Optional Feature:
- Macro: SAMPLE_QUAD_NVALID_EN.
- Defined: adds output port out_nvalid [2:0], the number of real (non-padded) lanes in the held quad, 1..4. It resets to 0 and is registered alongside out_a..out_d.
- Undefined: the port and its register are absent. Behaviour is otherwise identical.

Decomposition:
- Package quad_pkg:
  - QUAD_LANES = 4
  - cnt_t (2-bit)
  - quad_t struct of four WIDTH-default lanes
  - pad-value constant (all-ones)
- One natural sub-module: quad_out_reg, the holding register with its valid/ready logic and simultaneous drain/reload.
- Fill counter and staging stay in the top module.

Test Plan:
- Reset, then samples 9,3,7,5 on consecutive cycles with out_ready=1 -> one cycle after the 4th accept: out_valid=1, a..d = 9,3,7,5. in_ready never drops.
- Continuous stream 1..12 with out_ready=1 -> three quads (1-4, 5-8, 9-12) on back-to-back group boundaries. No in_ready deassertion.
- Samples 20,10 then flush alone -> quad 20,10,FF,FF. With SAMPLE_QUAD_NVALID_EN defined, out_nvalid=2.
- out_ready=0 after the first quad completes; feed 4 more samples -> 4th sample stalled (in_ready=0). Raise out_ready -> first quad transfers and second loads on the same edge. out_valid stays 1.
- Flush with cnt=0 -> no out_valid. Flush concurrent with the 3rd sample (11,22,33) -> quad 11,22,33,FF.
- Assert reset with cnt=2 and a held quad -> next cycle out_valid=0, outputs 0. The following 4 samples form a fresh quad with no stale lanes.
